// File: rtl/aquarium_climate_fsm.sv
// aquarium_climate_fsm
//   Drives the hot and cold circulation pumps from registered temperature and
//   humidity readings. Decisions are taken once per prescaled tick. Features a
//   temperature hysteresis band, a minimum pump run time, a rest period after
//   every run, and a debounced water-level fault.
//
//   Optional feature macro: AQUA_FAULT_LATCH_EN
//     defined     -> level_fault latches until clr; the FSM then stays in IDLE
//     not defined -> level_fault clears after DEBOUNCE_TICKS good ticks
//
// Ports
//   clk                 system clock, rising edge
//   clr                 synchronous active-high reset
//   temperature_sensor  raw temperature            [SENSOR_W]
//   humidity_sensor     raw humidity               [SENSOR_W]
//   set_temperature     temperature setpoint       [SENSOR_W]
//   set_humidity        humidity setpoint          [SENSOR_W]
//   waterlvl_sensor     water-level probe
//   water_level_ok      probe polarity reference (good when probe differs)
//   pump_control_hot    hot pump enable
//   pump_control_cold   cold pump enable
//   level_fault         debounced water-level fault
//   fsm_state           IDLE=0, HEAT=1, COOL=2, REST=3
//
// state | meaning
// IDLE  | both pumps off, waiting for a heat or cool request
// HEAT  | hot pump running
// COOL  | cold pump running
// REST  | both pumps off for REST_TICKS after any run
module aquarium_climate_fsm #(
  parameter int SENSOR_W       = 3,
  parameter int TICK_DIV       = 50000000,
  parameter int HYST           = 1,
  parameter int MIN_ON_TICKS   = 4,
  parameter int REST_TICKS     = 2,
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [SENSOR_W-1:0] temperature_sensor,
  input  logic [SENSOR_W-1:0] humidity_sensor,
  input  logic [SENSOR_W-1:0] set_temperature,
  input  logic [SENSOR_W-1:0] set_humidity,
  input  logic                waterlvl_sensor,
  input  logic                water_level_ok,
  output logic                pump_control_hot,
  output logic                pump_control_cold,
  output logic                level_fault,
  output logic [1:0]          fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HEAT = 2'd1;
  localparam logic [1:0] COOL = 2'd2;
  localparam logic [1:0] REST = 2'd3;

  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W   = (DEBOUNCE_TICKS < 1) ? 1 : $clog2(DEBOUNCE_TICKS + 1);
  localparam int RUN_MAX = (MIN_ON_TICKS > REST_TICKS) ?
                           ((MIN_ON_TICKS > 1) ? MIN_ON_TICKS : 1) :
                           ((REST_TICKS > 1) ? REST_TICKS : 1);
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_TICKS);
  localparam logic [RUN_W-1:0]  RUN_SAT  = RUN_W'(RUN_MAX);
  localparam logic [SENSOR_W:0] HYST_X   = (SENSOR_W + 1)'(HYST);

  logic [SENSOR_W-1:0] temp_q, hum_q, set_t_q, set_h_q;
  logic                lvl_q, lvl_ok_q;

  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [RUN_W-1:0]    run_cnt;
  logic [1:0]          state, state_nxt;
  logic [DEB_W-1:0]    bad_cnt, bad_nxt;
  logic                fault_nxt;
  logic                level_bad;

  logic [SENSOR_W:0]   temp_x, hum_x, set_t_x, set_h_x;
  logic                heat_req, cool_req, min_on_done, rest_done;

  always_ff @(posedge clk) begin
    if (clr) begin
      temp_q   <= '0;
      hum_q    <= '0;
      set_t_q  <= '0;
      set_h_q  <= '0;
      lvl_q    <= 1'b0;
      lvl_ok_q <= 1'b0;
    end else begin
      temp_q   <= temperature_sensor;
      hum_q    <= humidity_sensor;
      set_t_q  <= set_temperature;
      set_h_q  <= set_humidity;
      lvl_q    <= waterlvl_sensor;
      lvl_ok_q <= water_level_ok;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // One extra bit so setpoint + HYST cannot wrap.
  assign temp_x  = {1'b0, temp_q};
  assign hum_x   = {1'b0, hum_q};
  assign set_t_x = {1'b0, set_t_q};
  assign set_h_x = {1'b0, set_h_q};

  assign heat_req = (temp_x + HYST_X < set_t_x) && (hum_x > set_h_x);
  assign cool_req = (temp_x > set_t_x + HYST_X) && (hum_x < set_h_x);

  // Signed compares keep MIN_ON_TICKS/REST_TICKS of 0 well defined.
  assign min_on_done = (int'(run_cnt) >= MIN_ON_TICKS - 1);
  assign rest_done   = (int'(run_cnt) >= REST_TICKS - 1);

  assign level_bad = (lvl_q == lvl_ok_q);
  assign bad_nxt   = !level_bad ? '0 : ((bad_cnt == DEB_MAX) ? bad_cnt : bad_cnt + 1'b1);

`ifdef AQUA_FAULT_LATCH_EN
  assign fault_nxt = level_fault || (bad_nxt == DEB_MAX);
`else
  logic [DEB_W-1:0] good_cnt, good_nxt;

  assign good_nxt  = level_bad ? '0 : ((good_cnt == DEB_MAX) ? good_cnt : good_cnt + 1'b1);
  assign fault_nxt = (bad_nxt == DEB_MAX) ? 1'b1 :
                     (good_nxt == DEB_MAX) ? 1'b0 : level_fault;

  always_ff @(posedge clk) begin
    if (clr)       good_cnt <= '0;
    else if (tick) good_cnt <= good_nxt;
  end
`endif

  // The fault value computed for this tick gates the transition in the same tick.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!fault_nxt) begin
          if (heat_req)      state_nxt = HEAT;
          else if (cool_req) state_nxt = COOL;
        end
      end
      HEAT: if (fault_nxt || (min_on_done && temp_x >= set_t_x)) state_nxt = REST;
      COOL: if (fault_nxt || (min_on_done && temp_x <= set_t_x)) state_nxt = REST;
      REST: if (rest_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      div_cnt           <= '0;
      run_cnt           <= '0;
      bad_cnt           <= '0;
      state             <= IDLE;
      level_fault       <= 1'b0;
      pump_control_hot  <= 1'b0;
      pump_control_cold <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        bad_cnt     <= bad_nxt;
        level_fault <= fault_nxt;
        state       <= state_nxt;
        if (state_nxt != state)  run_cnt <= '0;
        else if (run_cnt != RUN_SAT) run_cnt <= run_cnt + 1'b1;
        pump_control_hot  <= (state_nxt == HEAT);
        pump_control_cold <= (state_nxt == COOL);
      end
    end
  end

  assign fsm_state = state;

endmodule
